// File: rtl/sound_rom_arbiter.sv
// Shares one SDRAM read slot among Z80 ROM and two OKI PCM channels,
// with a one-byte cache per requester so repeated addresses skip SDRAM.
module sound_rom_arbiter #(
    parameter int             AW       = 22,
    parameter logic [AW-1:0]  Z80_BASE = 22'h000000,
    parameter logic [AW-1:0]  PCM_BASE = 22'h020000
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          Z80_CS,
    input  logic [16:0]   Z80_ADDR,
    output logic          Z80_OK,
    output logic [7:0]    Z80_DATA,
    input  logic          PCM0_CS,
    input  logic [19:0]   PCM0_ADDR,
    output logic          PCM0_OK,
    output logic [7:0]    PCM0_DATA,
    input  logic          PCM1_CS,
    input  logic [19:0]   PCM1_ADDR,
    output logic          PCM1_OK,
    output logic [7:0]    PCM1_DATA,
    output logic          MEM_CS,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_OK,
    input  logic [7:0]    MEM_DATA
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    typedef enum logic [1:0] {G_Z80, G_PCM0, G_PCM1} gnt_t;

    state_t        state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    logic [19:0]   lat_q, lat_d;
    logic          rr_q, rr_d;
    logic          mem_cs_d;
    logic [AW-1:0] mem_addr_d;
    logic          fill;

    logic [16:0]   z80_tag_q;
    logic [19:0]   pcm0_tag_q, pcm1_tag_q;
    logic          z80_vld_q, pcm0_vld_q, pcm1_vld_q;

    logic z80_hit, pcm0_hit, pcm1_hit;
    logic z80_miss, pcm0_miss, pcm1_miss;

    assign z80_hit   = Z80_CS  && z80_vld_q  && (z80_tag_q  == Z80_ADDR);
    assign pcm0_hit  = PCM0_CS && pcm0_vld_q && (pcm0_tag_q == PCM0_ADDR);
    assign pcm1_hit  = PCM1_CS && pcm1_vld_q && (pcm1_tag_q == PCM1_ADDR);
    assign z80_miss  = Z80_CS  && !z80_hit;
    assign pcm0_miss = PCM0_CS && !pcm0_hit;
    assign pcm1_miss = PCM1_CS && !pcm1_hit;

    // Slot handshake: MEM_CS/MEM_ADDR are held until the first cycle with
    // MEM_OK=1, which completes the read; MEM_CS then drops for at least one
    // cycle (GAP) before the next request. MEM_OK outside REQ is ignored.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        lat_d      = lat_q;
        rr_d       = rr_q;
        mem_cs_d   = MEM_CS;
        mem_addr_d = MEM_ADDR;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                mem_cs_d = 1'b0;
                if (z80_miss) begin
                    gnt_d      = G_Z80;
                    lat_d      = {3'b000, Z80_ADDR};
                    mem_addr_d = Z80_BASE + {{(AW-17){1'b0}}, Z80_ADDR};
                    mem_cs_d   = 1'b1;
                    state_d    = REQ;
                end else if (pcm0_miss && (!pcm1_miss || !rr_q)) begin
                    gnt_d      = G_PCM0;
                    lat_d      = PCM0_ADDR;
                    mem_addr_d = PCM_BASE + {{(AW-20){1'b0}}, PCM0_ADDR};
                    mem_cs_d   = 1'b1;
                    rr_d       = 1'b1;
                    state_d    = REQ;
                end else if (pcm1_miss) begin
                    gnt_d      = G_PCM1;
                    lat_d      = PCM1_ADDR;
                    mem_addr_d = PCM_BASE + {{(AW-20){1'b0}}, PCM1_ADDR};
                    mem_cs_d   = 1'b1;
                    rr_d       = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (MEM_OK) begin
                    fill     = 1'b1;
                    mem_cs_d = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                mem_cs_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mem_cs_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Next-cycle view of each entry, so OK already reflects a fill in GAP.
    logic        z80_fill, pcm0_fill, pcm1_fill;
    logic        z80_vld_d, pcm0_vld_d, pcm1_vld_d;
    logic [16:0] z80_tag_d;
    logic [19:0] pcm0_tag_d, pcm1_tag_d;

    assign z80_fill   = fill && (gnt_q == G_Z80);
    assign pcm0_fill  = fill && (gnt_q == G_PCM0);
    assign pcm1_fill  = fill && (gnt_q == G_PCM1);
    assign z80_vld_d  = z80_vld_q  || z80_fill;
    assign pcm0_vld_d = pcm0_vld_q || pcm0_fill;
    assign pcm1_vld_d = pcm1_vld_q || pcm1_fill;
    assign z80_tag_d  = z80_fill  ? lat_q[16:0] : z80_tag_q;
    assign pcm0_tag_d = pcm0_fill ? lat_q       : pcm0_tag_q;
    assign pcm1_tag_d = pcm1_fill ? lat_q       : pcm1_tag_q;

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q    <= IDLE;
            gnt_q      <= G_Z80;
            lat_q      <= '0;
            rr_q       <= 1'b0;
            MEM_CS     <= 1'b0;
            MEM_ADDR   <= '0;
            z80_vld_q  <= 1'b0;
            pcm0_vld_q <= 1'b0;
            pcm1_vld_q <= 1'b0;
            z80_tag_q  <= '0;
            pcm0_tag_q <= '0;
            pcm1_tag_q <= '0;
            Z80_DATA   <= 8'h00;
            PCM0_DATA  <= 8'h00;
            PCM1_DATA  <= 8'h00;
            Z80_OK     <= 1'b0;
            PCM0_OK    <= 1'b0;
            PCM1_OK    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            lat_q      <= lat_d;
            rr_q       <= rr_d;
            MEM_CS     <= mem_cs_d;
            MEM_ADDR   <= mem_addr_d;
            z80_vld_q  <= z80_vld_d;
            pcm0_vld_q <= pcm0_vld_d;
            pcm1_vld_q <= pcm1_vld_d;
            z80_tag_q  <= z80_tag_d;
            pcm0_tag_q <= pcm0_tag_d;
            pcm1_tag_q <= pcm1_tag_d;
            if (z80_fill)  Z80_DATA  <= MEM_DATA;
            if (pcm0_fill) PCM0_DATA <= MEM_DATA;
            if (pcm1_fill) PCM1_DATA <= MEM_DATA;
            Z80_OK  <= Z80_CS  && z80_vld_d  && (z80_tag_d  == Z80_ADDR);
            PCM0_OK <= PCM0_CS && pcm0_vld_d && (pcm0_tag_d == PCM0_ADDR);
            PCM1_OK <= PCM1_CS && pcm1_vld_d && (pcm1_tag_d == PCM1_ADDR);
        end
    end
endmodule

// File: doc/sound_rom_arbiter.md
Name: sound_rom_arbiter

Overview:
- Shares one SDRAM read slot between three sound-side requesters: Z80 program ROM, OKI ADPCM channel 0 and OKI ADPCM channel 1.
- Sits between the sound subsystem's Z80 ROM and PCM ROM ports and the SDRAM controller slot.
- Holds one cached byte per requester, so a requester that re-presents the same address is served without an SDRAM access.
- Removes the need for separate SDRAM slots per requester and for a permanently asserted PCM chip-select.

Parameters:
- AW, 22: SDRAM byte address width.
- Z80_BASE, 22'h000000: SDRAM byte offset of the Z80 ROM region.
- PCM_BASE, 22'h020000: SDRAM byte offset of the PCM ROM region.

Ports:
- CLK96  in  1  sound clock; all logic is on its rising edge.
- RESET96  in  1  reset, synchronous and active-high.
- Z80_CS  in  1  Z80 ROM request.
- Z80_ADDR  in  17  Z80 ROM byte address.
- Z80_OK  out  1  Z80_DATA is valid for the current Z80_ADDR.
- Z80_DATA  out  8  Z80 ROM data.
- PCM0_CS  in  1  OKI0 request.
- PCM0_ADDR  in  20  OKI0 PCM byte address, after banking.
- PCM0_OK  out  1  PCM0_DATA is valid for the current PCM0_ADDR.
- PCM0_DATA  out  8  OKI0 data.
- PCM1_CS  in  1  OKI1 request.
- PCM1_ADDR  in  20  OKI1 PCM byte address, after banking.
- PCM1_OK  out  1  PCM1_DATA is valid for the current PCM1_ADDR.
- PCM1_DATA  out  8  OKI1 data.
- MEM_CS  out  1  SDRAM slot request.
- MEM_ADDR  out  AW  SDRAM byte address.
- MEM_OK  in  1  SDRAM data valid.
- MEM_DATA  in  8  SDRAM read data.

Behaviour:
- Per-requester cache entry r in {Z80, PCM0, PCM1}:
  - Entry holds a tag (address of the issuing requester's width), a data byte and a valid bit.
  - Hit(r) = r_CS && valid(r) && tag(r)==r_ADDR.
  - Miss(r) = r_CS && !Hit(r).
- OK outputs are registered: r_OK <= Hit(r) every cycle.
  - Latency from a stable address on a hit is therefore one cycle.
  - r_DATA = data(r) as a register; it changes only on a fill.
- FSM states: IDLE, REQ, GAP.
  - IDLE:
    - If any miss exists, pick a grant (priority below).
    - Latch the requester id and its address, drive MEM_ADDR, set MEM_CS=1, go to REQ.
    - Otherwise MEM_CS=0.
  - REQ:
    - MEM_CS and MEM_ADDR are held stable until a cycle with MEM_OK=1.
    - In that cycle: data(g)<=MEM_DATA, tag(g)<=latched address, valid(g)<=1, MEM_CS<=0, go to GAP.
  - GAP:
    - One cycle with MEM_CS=0; the registered OK reflects the fill here.
    - Then return to IDLE.
    - Back-to-back accesses are therefore separated by at least one cycle with MEM_CS low.
- Priority:
  - Z80 miss always wins, because the CPU stalls on ROM wait.
  - Between PCM0 and PCM1, round-robin: a one-bit pointer names the favoured channel; it flips to the other channel after every PCM grant.
  - Reset value of the pointer = PCM0.
- Address mapping:
  - Z80: MEM_ADDR = Z80_BASE + zero-extended Z80_ADDR.
  - PCM0 and PCM1: MEM_ADDR = PCM_BASE + zero-extended PCMx_ADDR.
  - Sums are modulo 2^AW; no overflow flag.
- Address change mid-transaction:
  - The in-flight access completes with its latched address and is stored under that tag.
  - The requester then sees a miss and is re-arbitrated.
  - Its OK stays low throughout.
- CS dropped mid-transaction: the access still completes and fills the entry; OK stays low while CS is low.
- A hit never generates an SDRAM access; a requester with a hit is not eligible for grant.
- MEM_OK in IDLE or GAP is ignored.
- Reset values (RESET96 high, any state):
  - state=IDLE, MEM_CS=0, MEM_ADDR=0.
  - All valid bits=0, all OK=0, all DATA=8'h00.
  - Round-robin pointer=PCM0.
  - An in-flight access is abandoned; a MEM_OK arriving after reset is ignored.
- There are no timeouts; a slot that never returns MEM_OK stalls all misses.

Test Plan:
- Reset, then Z80_CS=1, Z80_ADDR=17'h00100, SDRAM returns 8'hA5 after 3 cycles:
  - MEM_ADDR=22'h000100.
  - MEM_CS high for 4 cycles.
  - Z80_OK=1 and Z80_DATA=8'hA5 one cycle after the MEM_OK cycle.
  - No further MEM_CS while the address is held.
- PCM0_CS=PCM1_CS=1 with addresses 20'h00010 and 20'h00020, both misses:
  - First grant MEM_ADDR=22'h020010, then 22'h020020.
  - At least one MEM_CS=0 cycle between the two grants.
- Z80 and PCM1 miss in the same IDLE cycle: Z80 is granted first; PCM1 is granted next.
- PCM0 address stepping 20'h00000 to 20'h00001 every 40 cycles while PCM1 streams: grants alternate PCM0/PCM1; neither channel is starved.
- PCM0_ADDR changes from 20'h00400 to 20'h00401 during REQ:
  - First fill is tagged 00400 and PCM0_OK stays 0.
  - A second access to 22'h020401 follows; PCM0_OK=1 only after it completes.
- Assert RESET96 for one cycle during REQ:
  - MEM_CS=0 the next cycle; all OK=0.
  - A stale MEM_OK=1 two cycles later causes no fill.
  - A fresh request re-issues normally.
